// File: rtl/pipe_in_arbiter.sv
// pipe_in_arbiter
// ---------------
// Shares one PipeIn enqueue port among NUM_REQ indication packers. Each
// packer presents a fully packed message. The arbiter grants one requester
// per cycle in round-robin order and captures the accepted message in a
// one-entry holding register. The holding register then drives the pipe
// enqueue with ENA only while the pipe reports RDY.
//
// Handshake semantics (both sides): a transfer happens in a cycle where ENA
// and RDY are both high at the rising clock edge. RDY never depends on the
// ENA of the same port. ENA without RDY is ignored.
//
// Ports:
//   CLK            clock
//   nRST           asynchronous active-low reset
//   req_pending    [NUM_REQ]            requester i has a message ready
//   in_enq__ENA    [NUM_REQ]            requester i enqueues this cycle
//   in_enq_v       [NUM_REQ*DATA_WIDTH] payloads, slice i at i*DATA_WIDTH
//   in_enq__RDY    [NUM_REQ]            grant, one-hot or zero
//   pipe_enq__RDY  downstream pipe can accept
//   pipe_enq__ENA  enqueue to pipe (full & pipe_enq__RDY)
//   pipe_enq_v     [DATA_WIDTH]         held message
//   grant_id       [ID_WIDTH]           requester index of held message
//
// Optional feature, macro PIPE_IN_ARBITER_STATS_EN:
//   stat_grants    [NUM_REQ*16]  per-requester saturating accept counters
//   stat_stall     [16]          saturating count of full & !pipe_enq__RDY
//   stat_clear     synchronous clear of all counters, wins over increment

module pipe_in_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req_pending,
  input  logic [NUM_REQ-1:0]            in_enq__ENA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_enq_v,
  output logic [NUM_REQ-1:0]            in_enq__RDY,
  input  logic                          pipe_enq__RDY,
  output logic                          pipe_enq__ENA,
  output logic [DATA_WIDTH-1:0]         pipe_enq_v,
  output logic [ID_WIDTH-1:0]           grant_id
`ifdef PIPE_IN_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_grants,
  output logic [15:0]                   stat_stall,
  input  logic                          stat_clear
`endif
);

  logic                  full;
  logic [DATA_WIDTH-1:0] hold_v;
  logic [ID_WIDTH-1:0]   hold_id;
  logic [ID_WIDTH-1:0]   last;

  logic [NUM_REQ-1:0]    upper_req;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  found;
  logic                  any_req;
  logic                  can_accept;
  logic [NUM_REQ-1:0]    acc_oh;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_data;

  // Round-robin search starting at last+1 with wrap. Requesters above the
  // pointer are searched first. If none of them is pending, the search
  // falls back to the lowest pending index, which is the wrapped part.
  always_comb begin
    upper_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_req[i] = req_pending[i] & (ID_WIDTH'(i) > last);
    end
    found  = 1'b0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper_req[i]) begin
        found  = 1'b1;
        sel_id = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_pending[i]) begin
        found  = 1'b1;
        sel_id = ID_WIDTH'(i);
      end
    end
  end

  assign any_req    = |req_pending;
  // A full register can still accept when it drains in the same cycle.
  // This gives one message per cycle.
  assign can_accept = ~full | pipe_enq__RDY;

  // Grants are held off while nRST is asserted, so no requester sees RDY
  // during reset.
  always_comb begin
    in_enq__RDY = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_enq__RDY[i] = nRST & can_accept & any_req & (sel_id == ID_WIDTH'(i));
    end
  end

  // ENA is qualified by RDY, so an enqueue by a requester without the grant
  // has no effect.
  assign acc_oh = in_enq__ENA & in_enq__RDY;
  assign accept = |acc_oh;

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_oh[i]) acc_data = in_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign pipe_enq__ENA = full & pipe_enq__RDY;
  assign pipe_enq_v    = hold_v;
  assign grant_id      = hold_id;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full    <= 1'b0;
      hold_v  <= '0;
      hold_id <= '0;
      last    <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        hold_v  <= acc_data;
        hold_id <= sel_id;
        full    <= 1'b1;
        last    <= sel_id;
      end else if (pipe_enq__ENA) begin
        // After a drain hold_v is stale and is not used again.
        full <= 1'b0;
      end
    end
  end

`ifdef PIPE_IN_ARBITER_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_oh[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      if (full && !pipe_enq__RDY && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*16 +: 16] = grant_cnt[g];
  end
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_in_arbiter.sv
// Testbench for pipe_in_arbiter (NUM_REQ=4, DATA_WIDTH=128, ID_WIDTH=4).
// Requester i always presents payload 0xA0+i. Expected {grant_id, data}
// pairs go into a queue as stimulus is set up. Each pipe enqueue pops one
// pair and compares it. Optional stats checks are built with
// PIPE_IN_ARBITER_STATS_EN.

module tb_pipe_in_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 128;
  localparam int IW   = 4;
  localparam int EW   = IW + DW;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [NREQ-1:0]  req_pending;
  logic [NREQ-1:0]  in_enq__ENA;
  logic [NREQ*DW-1:0] in_enq_v;
  logic [NREQ-1:0]  in_enq__RDY;
  logic             pipe_enq__RDY;
  logic             pipe_enq__ENA;
  logic [DW-1:0]    pipe_enq_v;
  logic [IW-1:0]    grant_id;
`ifdef PIPE_IN_ARBITER_STATS_EN
  logic [NREQ*16-1:0] stat_grants;
  logic [15:0]        stat_stall;
  logic               stat_clear;
`endif

  pipe_in_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .req_pending(req_pending),
    .in_enq__ENA(in_enq__ENA),
    .in_enq_v(in_enq_v),
    .in_enq__RDY(in_enq__RDY),
    .pipe_enq__RDY(pipe_enq__RDY),
    .pipe_enq__ENA(pipe_enq__ENA),
    .pipe_enq_v(pipe_enq_v),
    .grant_id(grant_id)
`ifdef PIPE_IN_ARBITER_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall(stat_stall),
    .stat_clear(stat_clear)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  logic [NREQ-1:0] rdy_seen;
  logic            pe_seen;
  logic [DW-1:0]   v_seen;

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int id);
    return {IW'(id), DW'(160 + id)};
  endfunction

  // One cycle as the requesters and the pipe. Inputs are driven after the
  // falling edge and outputs are sampled 1 time unit later. Granted
  // requesters in ena then enqueue. force_ena is OR'ed in without regard
  // to RDY.
  task automatic step(input logic [NREQ-1:0] pend, input logic [NREQ-1:0] ena,
                      input logic prdy, input logic [NREQ-1:0] force_ena);
    @(negedge CLK);
    req_pending   = pend;
    pipe_enq__RDY = prdy;
    in_enq__ENA   = '0;
    #1;
    rdy_seen = in_enq__RDY;
    pe_seen  = pipe_enq__ENA;
    v_seen   = pipe_enq_v;
    chk("rdy_onehot0", EW'($onehot0(in_enq__RDY)), 1);
    if (pipe_enq__ENA) begin
      if (exp_q.size() == 0) chk("unexpected_enq", EW'(pipe_enq__ENA), 0);
      else chk("pipe_out", {grant_id, pipe_enq_v}, exp_q.pop_front());
    end
    in_enq__ENA = (in_enq__RDY & ena) | force_ena;
  endtask

  initial begin
    nRST          = 1'b0;
    req_pending   = '1;
    in_enq__ENA   = '0;
    pipe_enq__RDY = 1'b1;
    for (int i = 0; i < NREQ; i++) in_enq_v[i*DW +: DW] = DW'(160 + i);
`ifdef PIPE_IN_ARBITER_STATS_EN
    stat_clear = 1'b0;
`endif

    // reset state, with everything pending
    #12;
    chk("rst_rdy", EW'(in_enq__RDY), 0);
    chk("rst_pipe_ena", EW'(pipe_enq__ENA), 0);
    chk("rst_pipe_v", EW'(pipe_enq_v), 0);
    chk("rst_grant_id", EW'(grant_id), 0);
    @(negedge CLK);
    nRST = 1'b1;

    // first grant after reset goes to requester 0
    step(4'b0001, 4'b0000, 1'b1, 4'b0000);
    chk("post_rst_rdy", EW'(rdy_seen), 4'b0001);
    chk("post_rst_pe", EW'(pe_seen), 0);

    // fairness: all requesters pending, one message per cycle
    for (int k = 0; k < 8; k++) exp_q.push_back(ent(k % 4));
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 4'b1111, 1'b1, 4'b0000);
      chk("fair_rdy", EW'(rdy_seen), EW'(1 << (k % 4)));
      if (k > 0) chk("fair_tput", EW'(pe_seen), 1);
    end
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("fair_drained", EW'(exp_q.size()), 0);

    // backpressure: register holds 0xA1 while the pipe stalls
    exp_q.push_back(ent(1));
    exp_q.push_back(ent(2));
    step(4'b0010, 4'b1111, 1'b1, 4'b0000);
    chk("bp_fill_rdy", EW'(rdy_seen), 4'b0010);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 4'b1111, 1'b0, 4'b0000);
      chk("bp_rdy", EW'(rdy_seen), 0);
      chk("bp_pe", EW'(pe_seen), 0);
      chk("bp_v", EW'(v_seen), EW'(8'hA1));
    end
    step(4'b1111, 4'b0100, 1'b1, 4'b0000);
    chk("bp_release_rdy", EW'(rdy_seen), 4'b0100);
    chk("bp_release_pe", EW'(pe_seen), 1);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // wrap/skip: move pointer to 3, then only 1 and 3 pending
    exp_q.push_back(ent(3));
    step(4'b1000, 4'b1111, 1'b1, 4'b0000);
    for (int k = 0; k < 4; k++) exp_q.push_back(ent((k % 2) ? 3 : 1));
    for (int k = 0; k < 4; k++) begin
      step(4'b1010, 4'b1111, 1'b1, 4'b0000);
      chk("wrap_rdy", EW'(rdy_seen), (k % 2) ? 4'b1000 : 4'b0010);
    end
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // pending without ENA keeps the grant
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 4'b0000, 1'b1, 4'b0000);
      chk("noena_rdy", EW'(rdy_seen), 4'b0100);
      chk("noena_pe", EW'(pe_seen), 0);
    end
    exp_q.push_back(ent(2));
    step(4'b0100, 4'b0100, 1'b1, 4'b0000);
    chk("noena_accept_rdy", EW'(rdy_seen), 4'b0100);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("noena_sent", EW'(pe_seen), 1);

    // single requester granted every cycle
    for (int k = 0; k < 3; k++) exp_q.push_back(ent(0));
    for (int k = 0; k < 3; k++) begin
      step(4'b0001, 4'b0001, 1'b1, 4'b0000);
      chk("single_rdy", EW'(rdy_seen), 4'b0001);
    end
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // illegal ENA without RDY is ignored
    step(4'b0000, 4'b0000, 1'b1, 4'b1111);
    step(4'b0001, 4'b0000, 1'b1, 4'b0010);
    chk("illegal_pe0", EW'(pe_seen), 0);
    chk("illegal_rdy", EW'(rdy_seen), 4'b0001);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("illegal_pe1", EW'(pe_seen), 0);

    // reset mid-operation: held message is discarded, pointer reset
    step(4'b0010, 4'b0010, 1'b0, 4'b0000);
    @(negedge CLK);
    req_pending   = '0;
    in_enq__ENA   = '0;
    pipe_enq__RDY = 1'b1;
    nRST          = 1'b0;
    #1;
    chk("midrst_pe", EW'(pipe_enq__ENA), 0);
    chk("midrst_v", EW'(pipe_enq_v), 0);
    chk("midrst_id", EW'(grant_id), 0);
    @(negedge CLK);
    nRST = 1'b1;
    step(4'b1111, 4'b0000, 1'b1, 4'b0000);
    chk("midrst_rdy", EW'(rdy_seen), 4'b0001);
    chk("midrst_no_enq", EW'(pe_seen), 0);

`ifdef PIPE_IN_ARBITER_STATS_EN
    chk("stat_rst_grants", EW'(stat_grants), 0);
    chk("stat_rst_stall", EW'(stat_stall), 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(0));
    for (int k = 0; k < 4; k++) step(4'b0001, 4'b0001, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 1'b0, 4'b0000);
    for (int k = 0; k < 3; k++) exp_q.push_back(ent(0));
    for (int k = 0; k < 3; k++) step(4'b0001, 4'b0001, 1'b1, 4'b0000);
    step(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("stat_grants0", EW'(stat_grants[15:0]), 7);
    chk("stat_grants_oth", EW'(stat_grants[63:16]), 0);
    chk("stat_stall", EW'(stat_stall), 3);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("stat_rst2_grants", EW'(stat_grants), 0);
    chk("stat_rst2_stall", EW'(stat_stall), 0);
    @(negedge CLK);
    nRST = 1'b1;
    // saturation: requester 0 accepted every cycle
    req_pending   = 4'b0001;
    in_enq__ENA   = 4'b0001;
    pipe_enq__RDY = 1'b1;
    repeat (65540) @(posedge CLK);
    @(negedge CLK);
    chk("stat_sat", EW'(stat_grants[15:0]), 16'hFFFF);
    stat_clear = 1'b1;
    @(negedge CLK);
    chk("stat_clear_prio", EW'(stat_grants[15:0]), 0);
    stat_clear  = 1'b0;
    req_pending = '0;
    in_enq__ENA = '0;
    @(negedge CLK);
`endif

    chk("sb_empty", EW'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_in_arbiter.md
Name: pipe_in_arbiter

Overview:
- Shares one PipeIn enqueue port among NUM_REQ method-to-pipe packers (indication serializers).
- Each packer presents a fully packed message. The arbiter picks one per cycle in round-robin order and holds it in a one-entry output register.
- It then drives pipe enq under the guarded-method rule: ENA only while RDY.
- Sits between the per-interface packers and the single host-bound pipe.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 128: packed message width in bits.
- ID_WIDTH, 4: width of grant_id; must be at least clog2(NUM_REQ).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_pending  in  NUM_REQ  bit i high when requester i has a message. Must not depend on in_enq__RDY.
- in_enq__ENA  in  NUM_REQ  bit i: requester i enqueues this cycle. Legal only while in_enq__RDY[i] is high.
- in_enq_v  in  NUM_REQ*DATA_WIDTH  message payloads. Slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- in_enq__RDY  out  NUM_REQ  one-hot or zero; grant to requester i.
- pipe_enq__RDY  in  1  downstream pipe can accept.
- pipe_enq__ENA  out  1  enqueue to pipe.
- pipe_enq_v  out  DATA_WIDTH  message to pipe.
- grant_id  out  ID_WIDTH  index of the requester whose message is in the holding register.

Behaviour:
- State: holding register hold_v, valid flag full, hold_id, round-robin pointer last (index of the last accepted requester).
- Reset, asynchronous on nRST low:
  - full=0, hold_v=0, hold_id=0, last=NUM_REQ-1, so requester 0 has first priority.
  - Outputs: pipe_enq__ENA=0, in_enq__RDY=0, pipe_enq_v=0, grant_id=0.
- Output side: pipe_enq__ENA = full & pipe_enq__RDY. pipe_enq_v = hold_v; grant_id = hold_id.
- can_accept = ~full | pipe_enq__RDY. This allows a simultaneous drain and refill, giving 1 message/cycle throughput.
- Grant selection, combinational:
  - sel = first i with req_pending[i] set, searching from last+1 upward with wrap modulo NUM_REQ.
  - in_enq__RDY[sel] = can_accept & |req_pending. All other bits are 0.
- Accept: when in_enq__ENA[sel] & in_enq__RDY[sel]:
  - hold_v <= slice sel; hold_id <= sel; full <= 1; last <= sel.
  - Latency is 1 cycle: the message appears on pipe_enq_v in the cycle after acceptance.
- Drain without refill: pipe_enq__ENA & no accept -> full <= 0. hold_v keeps its value, but it is don't-care.
- Pending without ENA: if req_pending[sel] is high but ENA is low, nothing is accepted and last is unchanged. The same requester keeps the grant next cycle.
- Illegal input: in_enq__ENA[j] with in_enq__RDY[j]=0 is ignored. No state change.
- Wrap: last=NUM_REQ-1 and requester 0 pending -> sel=0.
- Single requester: it is granted every cycle the register can accept.
- Backpressure: pipe_enq__RDY=0 with full=1 -> all in_enq__RDY=0. Register content stays stable until drained.
- Reset mid-operation: the held message is discarded and the pointer returns to its reset value. No partial enqueue reaches the pipe.
- Message ordering from any single requester is preserved.

Optional Feature:
- Macro: PIPE_IN_ARBITER_STATS_EN.
- With the macro defined:
  - Adds output stat_grants (NUM_REQ*16 bits): per-requester 16-bit saturating accept counters.
  - Adds output stat_stall (16 bits): saturating count of cycles with full=1 & pipe_enq__RDY=0.
  - Adds input stat_clear (1 bit): synchronous zero of all counters. It has priority over increment in the same cycle.
  - All counters reset to 0 on nRST.
- Without the macro: these ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset check: nRST low, then high. All RDY=0 and pipe_enq__ENA=0. With only req 0 pending and pipe_enq__RDY=1 -> in_enq__RDY=4'b0001.
- Fairness: NUM_REQ=4, all pending continuously, pipe_enq__RDY=1, payload = 0xA0+i. Pipe sees 0xA0,0xA1,0xA2,0xA3,0xA0..., one per cycle, with grant_id 0,1,2,3,0.
- Backpressure: register full with 0xA1, pipe_enq__RDY=0 for 5 cycles. in_enq__RDY=0 throughout, pipe_enq_v stays 0xA1, pipe_enq__ENA=0. On release, 0xA1 is sent once, then the next grant is req 2.
- Wrap/skip: last=3, only req 1 and req 3 pending. Order is 1,3,1,3.
- Pending without ENA: req 2 pending, ENA held low for 3 cycles. RDY stays 4'b0100, no pipe enqueue, then ENA=1 -> accepted.
- Reset mid-transfer plus stats (PIPE_IN_ARBITER_STATS_EN): 7 accepts from req 0, pipe stalled 3 cycles -> stat_grants[0]=7, stat_stall=3. Assert nRST low -> full=0 and counters=0. Counters saturate at 0xFFFF.
